// File: rtl/dac_spi_multichannel_if.sv
// Sample-vector handshake and DAC pin bundle for the multichannel LTC2624-class driver.
// The master is the upstream mixer side and the slave is the DAC driver.
interface dac_spi_multichannel_if #(
   parameter int DATA_W = 12,
   parameter int NUM_CH = 4
);
   logic [NUM_CH*DATA_W-1:0] sample_data;
   logic [NUM_CH-1:0]        ch_enable;
   logic                     sample_valid;
   logic                     sample_ready;
   logic                     busy;
   logic                     frame_done;
   logic                     MOSI;
   logic                     SCK;
   logic                     CS_N;
   logic                     CLR_N;

   modport master (
      output sample_data, ch_enable, sample_valid,
      input  sample_ready, busy, frame_done, MOSI, SCK, CS_N, CLR_N
   );

   modport slave (
      input  sample_data, ch_enable, sample_valid,
      output sample_ready, busy, frame_done, MOSI, SCK, CS_N, CLR_N
   );
endinterface

// File: rtl/dac_spi_multichannel.sv
// Multichannel serial DAC driver: latches one sample vector, then sends one 32-bit
// frame per enabled channel in ascending order with its own SCK, CS_N and CLR_N.
module dac_spi_multichannel #(
   parameter int         DATA_W  = 12,
   parameter int         NUM_CH  = 4,
   parameter int         CLK_DIV = 1,
   parameter logic [3:0] COMMAND = 4'b0011
) (
   input logic                    clk,
   input logic                    rst,
   dac_spi_multichannel_if.slave  bus
);

   localparam int             CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0]  DIV_LAST = CW'(CLK_DIV - 1);

   // Channel selection has no state of its own: it is folded into the cycle that starts a frame.
   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

   state_t                   state_r, state_s;
   logic [NUM_CH*DATA_W-1:0] data_r, data_s;
   logic [NUM_CH-1:0]        rem_r, rem_s;
   logic [31:0]              shreg_r, shreg_s;
   logic [6:0]               phase_r, phase_s;
   logic [CW-1:0]            div_r, div_s;
   logic                     sck_r, sck_s, cs_n_r, cs_n_s, mosi_r, mosi_s;
   logic                     busy_r, busy_s, done_r, done_s, ready_r, ready_s, clr_n_r;
   logic [NUM_CH-1:0]        src_mask_s;
   logic [NUM_CH*DATA_W-1:0] src_data_s;
   logic [4:0]               k_s;
   logic [31:0]              frame_s;

   function automatic logic [4:0] lowest(input logic [NUM_CH-1:0] m);
      lowest = 5'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) lowest = 5'(i);
      end
   endfunction

   function automatic logic [31:0] build_frame(input logic [4:0] k,
                                                input logic [NUM_CH*DATA_W-1:0] d);
      logic [DATA_W-1:0] s;
      logic [31:0]       f;
      s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (5'(i) == k) s = d[i*DATA_W +: DATA_W];
      end
      f = {8'hFF, COMMAND, k[3:0], 16'h0000};
      f[16-DATA_W +: DATA_W] = s;
      return f;
   endfunction

   // Next-state, datapath and output computation.
   always_comb begin
      state_s = state_r;  data_s = data_r;   rem_s = rem_r;   shreg_s = shreg_r;
      phase_s = phase_r;  div_s  = div_r;    sck_s = sck_r;   cs_n_s  = cs_n_r;
      mosi_s  = mosi_r;   busy_s = busy_r;   done_s = 1'b0;   ready_s = ready_r;
      if (state_r == GAP) begin
         src_mask_s = rem_r;
         src_data_s = data_r;
      end else begin
         src_mask_s = bus.ch_enable;
         src_data_s = bus.sample_data;
      end
      k_s     = lowest(src_mask_s);
      frame_s = build_frame(k_s, src_data_s);

      case (state_r)
         IDLE, DONE: begin
            ready_s = 1'b1;
            state_s = IDLE;
            if (bus.sample_valid && ready_r) begin
               data_s = bus.sample_data;
               if (src_mask_s != '0) begin
                  state_s = SHIFT;  shreg_s = frame_s;  mosi_s = frame_s[31];
                  cs_n_s  = 1'b0;   sck_s   = 1'b0;     busy_s = 1'b1;
                  ready_s = 1'b0;   phase_s = 7'd0;     div_s  = '0;
                  rem_s   = src_mask_s & (src_mask_s - NUM_CH'(1));
               end else begin
                  state_s = DONE;   done_s = 1'b1;   busy_s = 1'b0;   ready_s = 1'b1;
               end
            end else begin
               busy_s = 1'b0;
            end
         end
         SHIFT: begin
            if (div_r == DIV_LAST) begin
               div_s = '0;
               if (phase_r == 7'd63) begin
                  state_s = GAP;  phase_s = 7'd0;  cs_n_s = 1'b1;  sck_s = 1'b0;
               end else begin
                  phase_s = phase_r + 7'd1;
                  sck_s   = ~phase_r[0];
                  // Leaving an odd (SCK high) phase is a falling edge: advance MOSI.
                  if (phase_r[0]) begin
                     shreg_s = {shreg_r[30:0], 1'b0};
                     mosi_s  = shreg_r[30];
                  end else begin
                     shreg_s = shreg_r;
                  end
               end
            end else begin
               div_s = div_r + CW'(1);
            end
         end
         GAP: begin
            if (div_r == DIV_LAST) begin
               div_s = '0;
               if (phase_r == 7'd1) begin
                  if (rem_r != '0) begin
                     state_s = SHIFT;  shreg_s = frame_s;  mosi_s = frame_s[31];
                     cs_n_s  = 1'b0;   sck_s   = 1'b0;     phase_s = 7'd0;
                     rem_s   = rem_r & (rem_r - NUM_CH'(1));
                  end else begin
                     state_s = DONE;   done_s = 1'b1;   busy_s = 1'b0;   ready_s = 1'b1;
                  end
               end else begin
                  phase_s = phase_r + 7'd1;
               end
            end else begin
               div_s = div_r + CW'(1);
            end
         end
         default: begin
            state_s = IDLE;  cs_n_s = 1'b1;  sck_s = 1'b0;  busy_s = 1'b0;
         end
      endcase
   end

   // State and registered-output update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;  data_r <= '0;    rem_r  <= '0;    shreg_r <= 32'h0;
         phase_r <= 7'd0;  div_r  <= '0;    sck_r  <= 1'b0;  cs_n_r  <= 1'b1;
         mosi_r  <= 1'b0;  busy_r <= 1'b0;  done_r <= 1'b0;  ready_r <= 1'b0;
         clr_n_r <= 1'b0;
      end else begin
         state_r <= state_s;  data_r <= data_s;  rem_r  <= rem_s;   shreg_r <= shreg_s;
         phase_r <= phase_s;  div_r  <= div_s;   sck_r  <= sck_s;   cs_n_r  <= cs_n_s;
         mosi_r  <= mosi_s;   busy_r <= busy_s;  done_r <= done_s;  ready_r <= ready_s;
         clr_n_r <= 1'b1;
      end
   end

   assign bus.SCK          = sck_r;
   assign bus.CS_N         = cs_n_r;
   assign bus.MOSI         = mosi_r;
   assign bus.CLR_N        = clr_n_r;
   assign bus.busy         = busy_r;
   assign bus.frame_done   = done_r;
   assign bus.sample_ready = ready_r;

endmodule

// File: tb/tb_dac_spi_multichannel.sv
// Directed bench for dac_spi_multichannel: three instances cover the default build,
// a divided SCK with sparse enables, and a single 16-bit channel with back-to-back bursts.
module tb_dac_spi_multichannel;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // Cycle index, stable between edges.
   always @(posedge clk) cyc <= cyc + 1;

   dac_spi_multichannel_if #(.DATA_W(12), .NUM_CH(4)) if0 ();
   dac_spi_multichannel_if #(.DATA_W(12), .NUM_CH(4)) if1 ();
   dac_spi_multichannel_if #(.DATA_W(16), .NUM_CH(1)) if2 ();

   dac_spi_multichannel #(.DATA_W(12), .NUM_CH(4), .CLK_DIV(1), .COMMAND(4'b0011))
      dut0 (.clk(clk), .rst(rst), .bus(if0));
   dac_spi_multichannel #(.DATA_W(12), .NUM_CH(4), .CLK_DIV(3), .COMMAND(4'b0011))
      dut1 (.clk(clk), .rst(rst), .bus(if1));
   dac_spi_multichannel #(.DATA_W(16), .NUM_CH(1), .CLK_DIV(1), .COMMAND(4'b0011))
      dut2 (.clk(clk), .rst(rst), .bus(if2));

   // Per-instance frame recorder: CS_N window bounds, bits sampled on SCK rise, rise count.
   int          fr_cnt[3]       = '{default: 0};
   int          fr_start[3][16];
   int          fr_end[3][16];
   int          fr_rises[3][16];
   logic [31:0] fr_data[3][16];
   logic [31:0] sh[3]           = '{default: 32'h0};
   int          rises[3]        = '{default: 0};
   logic        prev_cs[3]      = '{default: 1'b1};
   logic        prev_sck[3]     = '{default: 1'b0};
   int          viol            = 0;

   task mon(input int i, input logic cs, input logic sck, input logic mosi);
      if (prev_cs[i] && !cs && fr_cnt[i] < 16) begin
         fr_start[i][fr_cnt[i]] <= cyc;
         sh[i]    <= 32'h0;
         rises[i] <= 0;
      end else if (!prev_cs[i] && cs && fr_cnt[i] < 16) begin
         fr_end[i][fr_cnt[i]]   <= cyc;
         fr_data[i][fr_cnt[i]]  <= sh[i];
         fr_rises[i][fr_cnt[i]] <= rises[i];
         fr_cnt[i] <= fr_cnt[i] + 1;
      end else if (sck && !prev_sck[i]) begin
         sh[i]    <= {sh[i][30:0], mosi};
         rises[i] <= rises[i] + 1;
      end
      if (cs && sck) viol <= viol + 1;
      prev_cs[i]  <= cs;
      prev_sck[i] <= sck;
   endtask

   always @(negedge clk) begin
      mon(0, if0.CS_N, if0.SCK, if0.MOSI);
      mon(1, if1.CS_N, if1.SCK, if1.MOSI);
      mon(2, if2.CS_N, if2.SCK, if2.MOSI);
   end

   task tick();
      @(posedge clk);
      #1;
   endtask

   task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic fd(input int i);
      case (i)
         0:       return if0.frame_done;
         1:       return if1.frame_done;
         default: return if2.frame_done;
      endcase
   endfunction

   task automatic wait_done(input int i, input int budget, output int dc);
      dc = -1;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (fd(i)) begin
            dc = cyc;
            break;
         end
      end
   endtask

   int          a, dc, d2, n0;
   logic [31:0] exp4[4] = '{32'hFF30ABC0, 32'hFF311230, 32'hFF32FFF0, 32'hFF330000};

   initial begin
      if0.sample_valid = 1'b0; if0.sample_data = '0; if0.ch_enable = '0;
      if1.sample_valid = 1'b0; if1.sample_data = '0; if1.ch_enable = '0;
      if2.sample_valid = 1'b0; if2.sample_data = '0; if2.ch_enable = '0;

      // Reset, then release
      repeat (3) tick();
      chk("rst_sck",   32'(if0.SCK),          32'd0);
      chk("rst_cs_n",  32'(if0.CS_N),         32'd1);
      chk("rst_clr_n", 32'(if0.CLR_N),        32'd0);
      chk("rst_ready", 32'(if0.sample_ready), 32'd0);
      chk("rst_busy",  32'(if0.busy),         32'd0);
      rst = 1'b0;
      tick();
      chk("rel_ready", 32'(if0.sample_ready), 32'd1);
      chk("rel_clr_n", 32'(if0.CLR_N),        32'd1);

      // Full burst, four channels, CLK_DIV=1
      if0.sample_data = {12'h000, 12'hFFF, 12'h123, 12'hABC};
      if0.ch_enable = 4'hF; if0.sample_valid = 1'b1;
      a = cyc; n0 = fr_cnt[0];
      tick();
      if0.sample_valid = 1'b0; if0.sample_data = '1; if0.ch_enable = 4'h0;
      chk("acc_busy",  32'(if0.busy),         32'd1);
      chk("acc_ready", 32'(if0.sample_ready), 32'd0);
      chk("acc_cs_n",  32'(if0.CS_N),         32'd0);
      wait_done(0, 400, dc);
      chk("burst_done_cyc", 32'(dc),                32'(a + 265));
      chk("burst_done_rdy", 32'(if0.sample_ready),  32'd1);
      chk("burst_done_bsy", 32'(if0.busy),          32'd0);
      chk("burst_nframes",  32'(fr_cnt[0]),         32'(n0 + 4));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("burst_start%0d", i), 32'(fr_start[0][n0+i]), 32'(a + 1 + 66*i));
         chk($sformatf("burst_width%0d", i), 32'(fr_end[0][n0+i] - fr_start[0][n0+i]), 32'd64);
         chk($sformatf("burst_rises%0d", i), 32'(fr_rises[0][n0+i]), 32'd32);
         chk($sformatf("burst_data%0d", i),  fr_data[0][n0+i], exp4[i]);
      end

      // Empty enable mask
      tick();
      n0 = fr_cnt[0];
      if0.ch_enable = 4'h0; if0.sample_valid = 1'b1;
      tick();
      if0.sample_valid = 1'b0;
      chk("empty_done",  32'(if0.frame_done),   32'd1);
      chk("empty_ready", 32'(if0.sample_ready), 32'd1);
      chk("empty_busy",  32'(if0.busy),         32'd0);
      repeat (4) tick();
      chk("empty_noframe", 32'(fr_cnt[0]), 32'(n0));

      // Reset during the 10th SCK high phase of frame 1
      if0.sample_data = {12'h444, 12'h333, 12'h222, 12'h111};
      if0.ch_enable = 4'hF; if0.sample_valid = 1'b1;
      a = cyc;
      tick();
      if0.sample_valid = 1'b0;
      repeat (a + 86 - cyc) tick();
      chk("rm_sck_high", 32'(if0.SCK),  32'd1);
      chk("rm_cs_low",   32'(if0.CS_N), 32'd0);
      rst = 1'b1;
      tick();
      chk("rm_cs_n", 32'(if0.CS_N), 32'd1);
      chk("rm_sck",  32'(if0.SCK),  32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("rm_ready", 32'(if0.sample_ready), 32'd1);
      n0 = fr_cnt[0];
      if0.sample_data = {12'h000, 12'h000, 12'h000, 12'h555};
      if0.ch_enable = 4'b0001; if0.sample_valid = 1'b1;
      a = cyc;
      tick();
      if0.sample_valid = 1'b0;
      wait_done(0, 100, dc);
      chk("rm_done_cyc", 32'(dc),                  32'(a + 67));
      chk("rm_data",     fr_data[0][n0],           32'hFF305550);
      chk("rm_rises",    32'(fr_rises[0][n0]),     32'd32);

      // Sparse enable with CLK_DIV=3
      if1.sample_data = {12'hC3F, 12'h333, 12'h2A5, 12'h111};
      if1.ch_enable = 4'b1010; if1.sample_valid = 1'b1;
      a = cyc; n0 = fr_cnt[1];
      tick();
      if1.sample_valid = 1'b0;
      wait_done(1, 600, dc);
      chk("sp_done_cyc", 32'(dc),                 32'(a + 397));
      chk("sp_nframes",  32'(fr_cnt[1]),          32'(n0 + 2));
      chk("sp_data0",    fr_data[1][n0],          32'hFF312A50);
      chk("sp_data1",    fr_data[1][n0+1],        32'hFF33C3F0);
      chk("sp_start0",   32'(fr_start[1][n0]),    32'(a + 1));
      chk("sp_width0",   32'(fr_end[1][n0] - fr_start[1][n0]),     32'd192);
      chk("sp_width1",   32'(fr_end[1][n0+1] - fr_start[1][n0+1]), 32'd192);
      chk("sp_gap",      32'(fr_start[1][n0+1] - fr_end[1][n0]),   32'd6);
      chk("sp_rises1",   32'(fr_rises[1][n0+1]),  32'd32);

      // Back-to-back accept, single 16-bit channel
      if2.sample_data = 16'h1234; if2.ch_enable = 1'b1; if2.sample_valid = 1'b1;
      a = cyc; n0 = fr_cnt[2];
      tick();
      if2.sample_data = 16'h8001;
      wait_done(2, 200, dc);
      chk("b2b_done1",  32'(dc),                32'(a + 67));
      chk("b2b_ready1", 32'(if2.sample_ready),  32'd1);
      d2 = dc;
      tick();
      if2.sample_valid = 1'b0;
      chk("b2b_cs_low", 32'(if2.CS_N), 32'd0);
      chk("b2b_busy",   32'(if2.busy), 32'd1);
      wait_done(2, 200, dc);
      chk("b2b_done2",  32'(dc),                32'(d2 + 67));
      chk("b2b_data0",  fr_data[2][n0],         32'hFF301234);
      chk("b2b_data1",  fr_data[2][n0+1],       32'hFF308001);
      chk("b2b_start1", 32'(fr_start[2][n0+1]), 32'(d2 + 1));
      chk("b2b_gap_ge3", 32'((fr_start[2][n0+1] - fr_end[2][n0]) >= 3), 32'd1);

      chk("sck_while_cs_high", 32'(viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dac_spi_multichannel.md
Name: dac_spi_multichannel

Overview:
- Parametrised serial DAC driver for LTC2624-class 32-bit SPI frames.
- Accepts one multi-channel sample vector through a valid/ready handshake.
- Serialises one frame per enabled channel, in ascending channel order, with internally generated SCK, CS_N and CLR_N.
- Sits between the sound mixer and the board DAC pins.
- Unlike the single-channel controller, it generates its own SCK division and chip select, and adds per-channel enable and a burst-done pulse.

Parameters:
- DATA_W, 12, sample width per channel; legal range 1..16.
- NUM_CH, 4, number of DAC channels; legal range 1..16.
- CLK_DIV, 1, SCK half-period in clk cycles; must be ≥1.
- COMMAND, 4'b0011, DAC command nibble (write-and-update).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sample_data  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- ch_enable  in  NUM_CH  bit k=1: send a frame for channel k
- sample_valid  in  1  upstream has a vector
- sample_ready  out  1  block can accept a vector
- busy  out  1  burst in progress
- frame_done  out  1  one-cycle pulse at end of burst
- MOSI  out  1  serial data, MSB first
- SCK  out  1  serial clock, idle low
- CS_N  out  1  DAC chip select, active-low
- CLR_N  out  1  DAC clear, active-low

Behaviour:
- Reset values (while rst=1): SCK=0, CS_N=1, MOSI=0, CLR_N=0, busy=0, frame_done=0, sample_ready=0. State=IDLE.
- After reset: CLR_N=1 and sample_ready=1 from the first cycle after rst falls.
- Reset mid-frame: the abort is immediate on the next clk edge. CS_N=1 and SCK=0 that cycle. The partial frame is discarded.
- Accept: valid&ready in cycle A. sample_data and ch_enable are latched, busy=1 from A+1, and sample_ready=0 from A+1 until burst end.
- States: IDLE -> SELECT -> SHIFT -> GAP -> SELECT ... -> DONE -> IDLE.
- SELECT: finds the lowest enabled, not-yet-sent channel k and loads a 32-bit shift register with {8'hFF, COMMAND, k[3:0], sample_k, (16-DATA_W) zeros}.
- SELECT is combinational within the entry cycle, so it consumes no cycle.
- Frame timing, relative to frame start cycle F:
  - CS_N=0 and MOSI=bit31 at F; SCK=0.
  - Rising edge n (1..32) at F+(2n-1)*CLK_DIV.
  - Falling edges at F+2n*CLK_DIV; the shift register shifts on each falling edge except the 32nd. MOSI changes only on falling edges.
  - At F+64*CLK_DIV: SCK=0 and CS_N=1 in the same cycle.
- GAP: CS_N high for 2*CLK_DIV cycles. The next frame starts at F+66*CLK_DIV.
- First frame F = A+1. With NUM_CH=4, CLK_DIV=1 and all channels enabled, frames start at A+1, A+67, A+133, A+199.
- DONE: this is the cycle after the last GAP ends, i.e. A+1+M*66*CLK_DIV for M enabled channels.
  - frame_done=1 and busy=0 in that cycle.
  - sample_ready=1 in that cycle, so back-to-back accept is allowed. The inter-burst CS_N high time is ≥2*CLK_DIV+1 cycles.
- ch_enable=0 for all channels: no CS_N/SCK activity. frame_done pulses at A+1 and ready returns at A+1.
- Sample narrower than 16 bits: zero-padded at the LSB. The address nibble is the channel index; channels ≥16 are illegal by the parameter range.
- sample_valid while busy is ignored (ready=0). Input changes after accept do not affect the burst in flight.
- SCK never toggles while CS_N=1. Exactly 32 rising edges occur per CS_N low window.

Test Plan:
- Reset then idle: rst=1 for 3 cycles -> SCK=0, CS_N=1, CLR_N=0, ready=0. The cycle after release -> ready=1, CLR_N=1.
- Single burst, NUM_CH=4, DATA_W=12, CLK_DIV=1, data ch0..3=12'hABC,12'h123,12'hFFF,12'h000, enable=4'hF:
  - Four CS_N low windows of 64 cycles each, starting at A+1, A+67, A+133, A+199.
  - Frame 0 sampled on SCK rising edges = 32'hFF30ABC0; frame 2 = 32'hFF32FFF0.
  - frame_done at A+265.
- Sparse enable 4'b1010, CLK_DIV=3: only channels 1 and 3 are sent, with addresses 4'h1 and 4'h3. Each CS_N window is 192 cycles and the gap is 6 cycles. frame_done at A+1+2*198=A+397.
- Empty enable 4'b0000: no CS_N fall; frame_done and ready both high at A+1.
- Reset mid-frame: assert rst during the 10th SCK high phase of frame 1 -> the next cycle has CS_N=1 and SCK=0. After release, a new vector 12'h555 on ch0 only produces frame 32'hFF305550.
- Back-to-back accept with DATA_W=16, NUM_CH=1: valid held high, second vector 16'h8001 accepted at the frame_done cycle. The second frame 32'hFF308001 starts one cycle later, and the CS_N high time between frames is ≥3 cycles.
